// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants and lane-packing helpers for the fetch slot.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Lane-0 reset PC; lane k starts PC_STRIDE*k bytes above it
  localparam logic [31:0] FETCH_RESET_PC = 32'h1c00_0000;
  localparam int          FETCH_EXC_W    = 7;
  localparam int          FETCH_INST_W   = 32;
  localparam int          PC_STRIDE      = 4;

  // Bit offset of a lane inside a packed multi-lane vector (lane 0 in LSBs)
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_drop_counter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_drop_counter
// Brief    : Saturating up/down count of outstanding cancelled memory
//            requests, with a sticky overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module fetch_drop_counter #(
  parameter  int MAX_DROP = 3,
  localparam int CNT_W    = $clog2(MAX_DROP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_req,
  output logic [CNT_W-1:0] cnt,
  output logic             drop,
  output logic             ovf
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_dec;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A response only retires a drop when one is outstanding; a cancel at the
  // ceiling with nothing retiring is lost and flagged.
  always_comb begin
    w_dec     = dec_req && (r_cnt != '0);
    w_sat     = inc && !w_dec && (r_cnt == CNT_W'(MAX_DROP));
    w_cnt_nxt = r_cnt;
    if (inc && !w_dec && !w_sat) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (!inc && w_dec) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Count register and sticky overflow, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_sat) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign cnt  = r_cnt;
  assign drop = (r_cnt != '0);
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/fetch_slot_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_slot_reg
// Brief    : pre-IF -> IF slot register: lane PCs, exception tags, request
//            flag, prediction buffer, cancelled-response tracking and a
//            one-entry held response buffer.
// Revision : 1.0  initial release
// ============================================================================
module fetch_slot_reg
  import fetch_pkg::*;
#(
  parameter int               LANES    = 2,
  parameter int               PC_W     = 32,
  parameter int               EXC_W    = FETCH_EXC_W,
  parameter int               PR_W     = 64,
  parameter int               INST_W   = FETCH_INST_W,
  parameter int               MAX_DROP = 3,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(FETCH_RESET_PC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  input  logic                          if_allowin_i,
  input  logic                          excep_flush_i,
  input  logic                          branch_flush_i,
  input  logic [LANES*PC_W-1:0]         in_pc_i,
  input  logic [LANES-1:0]              in_exc_en_i,
  input  logic [LANES*EXC_W-1:0]        in_exc_type_i,
  input  logic                          in_req_i,
  output logic                          if_valid_o,
  output logic [LANES*PC_W-1:0]         pc_o,
  output logic [LANES-1:0]              exc_en_o,
  output logic [LANES*EXC_W-1:0]        exc_type_o,
  output logic                          req_o,
  input  logic                          pr_we_i,
  input  logic [PR_W-1:0]               pr_data_i,
  output logic [PR_W-1:0]               pr_data_o,
  input  logic                          cancel_i,
  input  logic                          resp_valid_i,
  input  logic [LANES*INST_W-1:0]       resp_data_i,
  input  logic                          buf_hold_i,
  input  logic                          buf_consume_i,
  output logic                          drop_o,
  output logic                          buf_valid_o,
  output logic [LANES*INST_W-1:0]       buf_data_o,
  output logic [$clog2(MAX_DROP+1)-1:0] drop_cnt_o,
  output logic                          drop_ovf_o
);

  logic                    w_flush;
  logic                    w_load;
  logic                    w_buf_load;
  logic                    w_drop;
  logic                    r_valid;
  logic [LANES*PC_W-1:0]   r_pc;
  logic [LANES-1:0]        r_exc_en;
  logic [LANES*EXC_W-1:0]  r_exc_type;
  logic                    r_req;
  logic [PR_W-1:0]         r_pr_data;
  logic                    r_buf_valid;
  logic [LANES*INST_W-1:0] r_buf_data;

  assign w_flush = excep_flush_i || branch_flush_i;
  assign w_load  = in_valid_i && if_allowin_i;
  // A consume in the same cycle frees the entry for the incoming response
  assign w_buf_load = resp_valid_i && !w_drop && buf_hold_i &&
                      (!r_buf_valid || buf_consume_i);

  // Per-lane PC register; each lane has its own reset address
  for (genvar k = 0; k < LANES; k++) begin : g_lane_pc
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_pc[lane_lsb(k, PC_W) +: PC_W] <= RESET_PC + PC_W'(PC_STRIDE * k);
      end else if (w_load) begin
        r_pc[lane_lsb(k, PC_W) +: PC_W] <= in_pc_i[lane_lsb(k, PC_W) +: PC_W];
      end
    end
  end

  // Remaining payload follows the PC; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exc_en   <= '0;
      r_exc_type <= '0;
      r_req      <= 1'b0;
    end else if (w_load) begin
      r_exc_en   <= in_exc_en_i;
      r_exc_type <= in_exc_type_i;
      r_req      <= in_req_i;
    end
  end

  // Slot valid handshake; a flush kills the slot even while it is loading
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_valid <= 1'b0;
    end else if (if_allowin_i) begin
      r_valid <= in_valid_i;
    end
  end

  // Prediction payload, written independently of the slot handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pr_data <= '0;
    end else if (pr_we_i) begin
      r_pr_data <= pr_data_i;
    end
  end

  // Held response buffer; flush drops the entry since its slot is gone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (w_flush) begin
      r_buf_valid <= 1'b0;
    end else if (w_buf_load) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= resp_data_i;
    end else if (buf_consume_i) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Cancelled responses keep arriving after a flush, so the counter only
  // sees cancels and responses, never the flush.
  fetch_drop_counter #(
    .MAX_DROP (MAX_DROP)
  ) u_drop_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cancel_i),
    .dec_req (resp_valid_i),
    .cnt     (drop_cnt_o),
    .drop    (w_drop),
    .ovf     (drop_ovf_o)
  );

  assign if_valid_o  = r_valid;
  assign pc_o        = r_pc;
  assign exc_en_o    = r_exc_en;
  assign exc_type_o  = r_exc_type;
  assign req_o       = r_req;
  assign pr_data_o   = r_pr_data;
  assign drop_o      = w_drop;
  assign buf_valid_o = r_buf_valid;
  assign buf_data_o  = r_buf_data;

endmodule
`default_nettype wire

// File: tb/tb_fetch_slot_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_slot_reg
// Brief    : Directed self-checking bench for fetch_slot_reg (default params).
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_slot_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, if_allowin_i, excep_flush_i, branch_flush_i;
  logic [63:0] in_pc_i;
  logic [1:0]  in_exc_en_i;
  logic [13:0] in_exc_type_i;
  logic        in_req_i;
  logic        if_valid_o;
  logic [63:0] pc_o;
  logic [1:0]  exc_en_o;
  logic [13:0] exc_type_o;
  logic        req_o;
  logic        pr_we_i;
  logic [63:0] pr_data_i, pr_data_o;
  logic        cancel_i, resp_valid_i;
  logic [63:0] resp_data_i;
  logic        buf_hold_i, buf_consume_i;
  logic        drop_o, buf_valid_o;
  logic [63:0] buf_data_o;
  logic [1:0]  drop_cnt_o;
  logic        drop_ovf_o;

  int checks = 0;
  int errors = 0;

  fetch_slot_reg dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .if_allowin_i(if_allowin_i),
    .excep_flush_i(excep_flush_i), .branch_flush_i(branch_flush_i),
    .in_pc_i(in_pc_i), .in_exc_en_i(in_exc_en_i), .in_exc_type_i(in_exc_type_i),
    .in_req_i(in_req_i), .if_valid_o(if_valid_o), .pc_o(pc_o),
    .exc_en_o(exc_en_o), .exc_type_o(exc_type_o), .req_o(req_o),
    .pr_we_i(pr_we_i), .pr_data_i(pr_data_i), .pr_data_o(pr_data_o),
    .cancel_i(cancel_i), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .buf_hold_i(buf_hold_i), .buf_consume_i(buf_consume_i),
    .drop_o(drop_o), .buf_valid_o(buf_valid_o), .buf_data_o(buf_data_o),
    .drop_cnt_o(drop_cnt_o), .drop_ovf_o(drop_ovf_o)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are then sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 0; if_allowin_i = 0; excep_flush_i = 0; branch_flush_i = 0;
    in_pc_i = '0; in_exc_en_i = '0; in_exc_type_i = '0; in_req_i = 0;
    pr_we_i = 0; pr_data_i = '0; cancel_i = 0; resp_valid_i = 0;
    resp_data_i = '0; buf_hold_i = 0; buf_consume_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    checks++;
    if (pc_o !== 64'h1c000004_1c000000) begin
      $display("FAIL reset_pc got %h exp %h", pc_o, 64'h1c000004_1c000000); errors++;
    end
    checks++;
    if ({if_valid_o, exc_en_o, exc_type_o, req_o, buf_valid_o, drop_o, drop_cnt_o, drop_ovf_o} !== '0) begin
      $display("FAIL reset_ctrl got v=%b ee=%b et=%h r=%b bv=%b d=%b c=%0d o=%b exp all 0",
               if_valid_o, exc_en_o, exc_type_o, req_o, buf_valid_o, drop_o, drop_cnt_o, drop_ovf_o);
      errors++;
    end
    checks++;
    if ({pr_data_o, buf_data_o} !== '0) begin
      $display("FAIL reset_data got pr=%h buf=%h exp 0", pr_data_o, buf_data_o); errors++;
    end
  endtask

  task automatic test_load_hold();
    in_valid_i = 1; if_allowin_i = 1; in_pc_i = {32'h104, 32'h100};
    in_exc_en_i = 2'b10; in_exc_type_i = {7'h15, 7'h03}; in_req_i = 1;
    pr_we_i = 1; pr_data_i = 64'hdead_beef_0123_4567;
    step();
    checks++;
    if (if_valid_o !== 1'b1 || pc_o !== {32'h104, 32'h100}) begin
      $display("FAIL load got v=%b pc=%h exp v=1 pc=%h", if_valid_o, pc_o, {32'h104, 32'h100}); errors++;
    end
    checks++;
    if (exc_en_o !== 2'b10 || exc_type_o !== {7'h15, 7'h03} || req_o !== 1'b1) begin
      $display("FAIL load_tags got ee=%b et=%h r=%b exp ee=10 et=%h r=1",
               exc_en_o, exc_type_o, req_o, {7'h15, 7'h03}); errors++;
    end
    checks++;
    if (pr_data_o !== 64'hdead_beef_0123_4567) begin
      $display("FAIL pr_write got %h exp deadbeef01234567", pr_data_o); errors++;
    end
    // stall: new inputs must not leak through
    if_allowin_i = 0; in_valid_i = 0; in_pc_i = {32'h999, 32'h888}; in_req_i = 0;
    pr_we_i = 0; pr_data_i = 64'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_valid_o !== 1'b1 || pc_o !== {32'h104, 32'h100} || req_o !== 1'b1 ||
          pr_data_o !== 64'hdead_beef_0123_4567) begin
        $display("FAIL hold%0d got v=%b pc=%h r=%b pr=%h exp v=1 pc=%h r=1 pr=deadbeef01234567",
                 i, if_valid_o, pc_o, req_o, pr_data_o, {32'h104, 32'h100}); errors++;
      end
    end
  endtask

  task automatic test_flush_load();
    cancel_i = 1; step(); cancel_i = 0;   // one outstanding drop to watch
    in_valid_i = 1; if_allowin_i = 1; in_pc_i = {32'h204, 32'h200}; branch_flush_i = 1;
    step();
    checks++;
    if (if_valid_o !== 1'b0 || pc_o !== {32'h204, 32'h200} || drop_cnt_o !== 2'd1) begin
      $display("FAIL branch_flush got v=%b pc=%h cnt=%0d exp v=0 pc=%h cnt=1",
               if_valid_o, pc_o, drop_cnt_o, {32'h204, 32'h200}); errors++;
    end
    branch_flush_i = 0;
    step();
    excep_flush_i = 1; if_allowin_i = 0;
    step();
    checks++;
    if (if_valid_o !== 1'b0 || pr_data_o !== 64'hdead_beef_0123_4567) begin
      $display("FAIL excep_flush got v=%b pr=%h exp v=0 pr=deadbeef01234567", if_valid_o, pr_data_o); errors++;
    end
    excep_flush_i = 0; in_valid_i = 0;
    resp_valid_i = 1; step(); resp_valid_i = 0;   // retire the drop
  endtask

  task automatic test_drop_sequence();
    cancel_i = 1; step(); step(); cancel_i = 0;
    checks++;
    if (drop_cnt_o !== 2'd2) begin
      $display("FAIL cancel2 got cnt=%0d exp 2", drop_cnt_o); errors++;
    end
    resp_valid_i = 1; buf_hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      resp_data_i = 64'h1000 + 64'(i);
      checks++;
      if (drop_o !== (i < 2)) begin
        $display("FAIL drop_resp%0d got %b exp %b", i, drop_o, (i < 2)); errors++;
      end
      step();
    end
    resp_valid_i = 0;
    checks++;
    if (buf_valid_o !== 1'b1 || buf_data_o !== 64'h1002 || drop_cnt_o !== 2'd0) begin
      $display("FAIL drop_buffer got bv=%b bd=%h cnt=%0d exp bv=1 bd=1002 cnt=0",
               buf_valid_o, buf_data_o, drop_cnt_o); errors++;
    end
    buf_consume_i = 1; buf_hold_i = 0; step(); buf_consume_i = 0;
    resp_valid_i = 1; resp_data_i = 64'h2222; step(); resp_valid_i = 0;
    checks++;
    if (buf_valid_o !== 1'b0) begin
      $display("FAIL nohold_buffer got bv=%b exp 0", buf_valid_o); errors++;
    end
  endtask

  task automatic test_saturate();
    cancel_i = 1; step(); step(); step();
    checks++;
    if (drop_cnt_o !== 2'd3 || drop_ovf_o !== 1'b0) begin
      $display("FAIL fill got cnt=%0d ovf=%b exp cnt=3 ovf=0", drop_cnt_o, drop_ovf_o); errors++;
    end
    step();
    checks++;
    if (drop_cnt_o !== 2'd3 || drop_ovf_o !== 1'b1) begin
      $display("FAIL saturate got cnt=%0d ovf=%b exp cnt=3 ovf=1", drop_cnt_o, drop_ovf_o); errors++;
    end
    cancel_i = 0; resp_valid_i = 1; buf_hold_i = 1; resp_data_i = 64'h3333; step();
    cancel_i = 1; step();
    checks++;
    if (drop_cnt_o !== 2'd2 || buf_valid_o !== 1'b0) begin
      $display("FAIL cancel_and_resp got cnt=%0d bv=%b exp cnt=2 bv=0", drop_cnt_o, buf_valid_o); errors++;
    end
    cancel_i = 0; step(); step(); resp_valid_i = 0; buf_hold_i = 0;
    checks++;
    if (drop_cnt_o !== 2'd0 || drop_ovf_o !== 1'b1 || buf_valid_o !== 1'b0) begin
      $display("FAIL drain got cnt=%0d ovf=%b bv=%b exp cnt=0 ovf=1 bv=0",
               drop_cnt_o, drop_ovf_o, buf_valid_o); errors++;
    end
  endtask

  task automatic test_buffer_consume();
    resp_valid_i = 1; buf_hold_i = 1; resp_data_i = 64'haaaa_0001; step();
    resp_data_i = 64'hbbbb_0002; step();
    checks++;
    if (buf_valid_o !== 1'b1 || buf_data_o !== 64'haaaa_0001) begin
      $display("FAIL buf_full_hold got bv=%b bd=%h exp bv=1 bd=aaaa0001", buf_valid_o, buf_data_o); errors++;
    end
    buf_consume_i = 1; resp_data_i = 64'hcccc_0003; step();
    checks++;
    if (buf_valid_o !== 1'b1 || buf_data_o !== 64'hcccc_0003) begin
      $display("FAIL buf_swap got bv=%b bd=%h exp bv=1 bd=cccc0003", buf_valid_o, buf_data_o); errors++;
    end
    resp_valid_i = 0; step();
    checks++;
    if (buf_valid_o !== 1'b0) begin
      $display("FAIL buf_consume got bv=%b exp 0", buf_valid_o); errors++;
    end
    buf_consume_i = 0; resp_valid_i = 1; resp_data_i = 64'hdddd_0004; step();
    resp_valid_i = 0; excep_flush_i = 1; step(); excep_flush_i = 0;
    checks++;
    if (buf_valid_o !== 1'b0) begin
      $display("FAIL buf_flush got bv=%b exp 0", buf_valid_o); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_flush_load();
    test_drop_sequence();
    test_saturate();
    test_buffer_consume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
